// File: rtl/wide_uart_pkg.sv
// Shared types, constants and the round-robin pick helper for the wide_uart scheduler.
package wide_uart_pkg;

  typedef enum logic {
    ARB = 1'b0,
    FWD = 1'b1
  } sched_state_t;

  localparam int unsigned UART_WORD_W = 64;
  localparam int unsigned MAX_REQ     = 8;

  // First set bit of valid scanning upward from ptr, wrapping at n; returns ptr if none set.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (!found && (k < n) && valid[idx[2:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == n - 1) ? 0 : idx + 1;
    end
  endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of requester IDs; dout shows the head combinationally.
module id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Storage array; contents need no reset since empty gates their use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wide_uart_rr_sched.sv
// Round-robin sharing of one wide_uart 64-bit channel; responses routed back in request order.
module wide_uart_rr_sched
  import wide_uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [UART_WORD_W*N_REQ-1:0]   req_tdata,
  input  logic [N_REQ-1:0]               req_tvalid,
  output logic [N_REQ-1:0]               req_tready,
  output logic [UART_WORD_W-1:0]         rsp_tdata,
  output logic [N_REQ-1:0]               rsp_tvalid,
  input  logic [N_REQ-1:0]               rsp_tready,
  output logic [UART_WORD_W-1:0]         u_s_tdata,
  output logic                           u_s_tvalid,
  input  logic                           u_s_tready,
  input  logic [UART_WORD_W-1:0]         u_m_tdata,
  input  logic                           u_m_tvalid,
  output logic                           u_m_tready,
  output logic [$clog2(MAX_OUT):0]       outstanding,
  output logic                           err_orphan
);

  sched_state_t    state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  int unsigned     pick;

  assign pick = rr_pick(MAX_REQ'(req_tvalid), 32'(rr_ptr), N_REQ);
  assign push = (state == FWD) && req_tvalid[grant] && u_s_tready;
  assign pop  = !fifo_empty && u_m_tvalid && rsp_tready[fifo_head];

  id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (grant),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // Forward FSM: ARB registers a grant only while the ID FIFO has room, FWD waits for the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ARB: begin
          if (!fifo_full && (|req_tvalid)) begin
            grant <= ID_W'(pick);
            state <= FWD;
          end
        end
        FWD: begin
          if (!req_tvalid[grant]) begin
            state <= ARB;
          end else if (u_s_tready) begin
            rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Granted requester drives the UART input stream directly while in FWD.
  always_comb begin
    u_s_tvalid = 1'b0;
    u_s_tdata  = '0;
    req_tready = '0;
    if (state == FWD) begin
      u_s_tvalid        = req_tvalid[grant];
      u_s_tdata         = req_tdata[UART_WORD_W*32'(grant) +: UART_WORD_W];
      req_tready[grant] = u_s_tready;
    end
  end

  // Responses go to the FIFO head; with nothing outstanding, words are swallowed.
  always_comb begin
    rsp_tvalid = '0;
    rsp_tdata  = '0;
    u_m_tready = 1'b1;
    if (!fifo_empty) begin
      rsp_tvalid[fifo_head] = u_m_tvalid;
      rsp_tdata             = u_m_tdata;
      u_m_tready            = rsp_tready[fifo_head];
    end
  end

  // Sticky flag for a response arriving with no request outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (fifo_empty && u_m_tvalid) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wide_uart_rr_sched.sv
// Scoreboard bench for wide_uart_rr_sched: directed scenarios plus a randomized traffic phase.
module tb_wide_uart_rr_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned MO = 4;
  localparam int          TMO = 600;

  logic            clk = 1'b0;
  logic            rst;
  logic [64*N-1:0] req_tdata;
  logic [N-1:0]    req_tvalid;
  logic [N-1:0]    req_tready;
  logic [63:0]     rsp_tdata;
  logic [N-1:0]    rsp_tvalid;
  logic [N-1:0]    rsp_tready;
  logic [63:0]     u_s_tdata;
  logic            u_s_tvalid;
  logic            u_s_tready;
  logic [63:0]     u_m_tdata;
  logic            u_m_tvalid;
  logic            u_m_tready;
  logic [2:0]      outstanding;
  logic            err_orphan;

  always #5 clk = ~clk;

  wide_uart_rr_sched #(.N_REQ(N), .MAX_OUT(MO)) dut (
    .clk (clk), .rst (rst),
    .req_tdata (req_tdata), .req_tvalid (req_tvalid), .req_tready (req_tready),
    .rsp_tdata (rsp_tdata), .rsp_tvalid (rsp_tvalid), .rsp_tready (rsp_tready),
    .u_s_tdata (u_s_tdata), .u_s_tvalid (u_s_tvalid), .u_s_tready (u_s_tready),
    .u_m_tdata (u_m_tdata), .u_m_tvalid (u_m_tvalid), .u_m_tready (u_m_tready),
    .outstanding (outstanding), .err_orphan (err_orphan)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: requests sent but not yet answered, in send order.
  int          mdl_cnt    = 0;
  bit          mdl_orphan = 1'b0;
  int          pend_id_q[$];
  int          exp_id_q[$];
  logic [63:0] exp_dat_q[$];
  int          exp_grant_q[$];
  bit          rnd_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_req(input int i, input logic [63:0] d);
    int n = 0;
    req_tdata[64*i +: 64] = d;
    req_tvalid[i]         = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_tready[i] && n < TMO);
    if (!req_tready[i]) fail_now("req_timeout");
    @(posedge clk);
    #1;
    req_tvalid[i] = 1'b0;
  endtask

  task automatic wait_pend();
    int n = 0;
    while (pend_id_q.size() == 0 && n < TMO) begin
      cyc(1);
      n++;
    end
    if (pend_id_q.size() == 0) fail_now("pend_timeout");
  endtask

  // Responder: the answer to the oldest unanswered request is expected at that requester.
  task automatic send_rsp(input logic [63:0] d);
    int n = 0;
    if (pend_id_q.size() > 0) begin
      exp_id_q.push_back(pend_id_q.pop_front());
      exp_dat_q.push_back(d);
    end
    u_m_tdata  = d;
    u_m_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!u_m_tready && n < TMO);
    if (!u_m_tready) fail_now("rsp_timeout");
    @(posedge clk);
    #1;
    u_m_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic req_stream(input int i, input int k);
    for (int j = 0; j < k; j++) begin
      cyc($urandom_range(0, 3));
      send_req(i, {4'(i), 28'($urandom), 32'($urandom)});
    end
  endtask

  task automatic rsp_stream(input int k);
    for (int j = 0; j < k; j++) begin
      wait_pend();
      cyc($urandom_range(0, 3));
      send_rsp({32'($urandom), 32'($urandom)});
    end
  endtask

  // Monitor: compares DUT outputs against the model each cycle and on every handshake.
  int m_id, m_rh, m_inc, m_dec;
  always @(negedge clk) begin
    if (rst) begin
      mdl_cnt    = 0;
      mdl_orphan = 1'b0;
      pend_id_q.delete();
      exp_id_q.delete();
      exp_dat_q.delete();
    end else begin
      m_inc = 0;
      m_dec = 0;
      check("outstanding", 64'(outstanding), 64'(mdl_cnt));
      check("err_orphan", 64'(err_orphan), 64'(mdl_orphan));
      check("rsp_onehot", 64'($onehot0(rsp_tvalid)), 64'd1);
      if (mdl_cnt == 0) begin
        check("empty_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        check("empty_u_m_tready", 64'(u_m_tready), 64'd1);
      end
      if (mdl_cnt == int'(MO)) check("full_no_fwd", 64'({u_s_tvalid, req_tready}), 64'd0);
      if (u_s_tvalid && u_s_tready) begin
        m_id = -1;
        for (int i = 0; i < int'(N); i++)
          if (m_id < 0 && req_tvalid[i] && req_tdata[64*i +: 64] == u_s_tdata) m_id = i;
        if (m_id < 0) begin
          checks++;
          failures++;
          $display("FAIL fwd_source: u_s_tdata %h matches no valid requester", u_s_tdata);
        end else begin
          check("fwd_tready", 64'(req_tready), 64'(1 << m_id));
          if (exp_grant_q.size() > 0) check("grant_order", 64'(m_id), 64'(exp_grant_q.pop_front()));
          pend_id_q.push_back(m_id);
          m_inc = 1;
        end
      end
      m_rh = -1;
      for (int i = 0; i < int'(N); i++)
        if (rsp_tvalid[i] && rsp_tready[i]) m_rh = i;
      if (u_m_tvalid && u_m_tready) begin
        if (mdl_cnt == 0) begin
          mdl_orphan = 1'b1;
        end else begin
          m_dec = 1;
          if (exp_id_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: response routed to %0d with none expected", m_rh);
          end else begin
            check("rsp_route", 64'(m_rh), 64'(exp_id_q.pop_front()));
            check("rsp_tdata", rsp_tdata, exp_dat_q.pop_front());
          end
        end
      end else if (m_rh >= 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_no_uart_hs: rsp handshake on %0d without UART handshake", m_rh);
      end
      mdl_cnt = mdl_cnt + m_inc - m_dec;
    end
  end

  initial begin
    int n;
    bit seen;
    rst        = 1'b1;
    req_tdata  = '0;
    req_tvalid = '0;
    rsp_tready = '1;
    u_s_tready = 1'b1;
    u_m_tdata  = 64'hDEAD_BEEF_CAFE_F00D;
    u_m_tvalid = 1'b0;
    rnd_done   = 1'b0;
    cyc(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_tready", 64'(req_tready), 64'd0);
    check("rst_u_s_tvalid", 64'(u_s_tvalid), 64'd0);
    check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    check("rst_rsp_tdata", rsp_tdata, 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk);
    #1;

    // Single request and response
    fork send_req(0, 64'h1122334455667788); join_none
    @(negedge clk);
    check("t1_latency_arb", 64'(u_s_tvalid), 64'd0);
    @(negedge clk);
    check("t1_u_s_tvalid", 64'(u_s_tvalid), 64'd1);
    check("t1_u_s_tdata", u_s_tdata, 64'h1122334455667788);
    wait fork;
    @(negedge clk);
    check("t1_outstanding1", 64'(outstanding), 64'd1);
    @(posedge clk);
    #1;
    fork send_rsp(64'hAABBCCDDEEFF0011); join_none
    @(negedge clk);
    check("t1_rsp_tvalid", 64'(rsp_tvalid), 64'h1);
    check("t1_rsp_tdata", rsp_tdata, 64'hAABBCCDDEEFF0011);
    wait fork;
    @(negedge clk);
    check("t1_outstanding0", 64'(outstanding), 64'd0);
    @(posedge clk);
    #1;

    // Round-robin with all requesters valid and a mid-sequence stall
    do_reset();
    for (int k = 0; k < 8; k++) exp_grant_q.push_back(k % int'(N));
    fork
      begin send_req(0, 64'h0000_0000_0000_0A00); send_req(0, 64'h0000_0000_0000_0A01); end
      begin send_req(1, 64'h1000_0000_0000_0B00); send_req(1, 64'h1000_0000_0000_0B01); end
      begin send_req(2, 64'h2000_0000_0000_0C00); send_req(2, 64'h2000_0000_0000_0C01); end
      begin send_req(3, 64'h3000_0000_0000_0D00); send_req(3, 64'h3000_0000_0000_0D01); end
      begin for (int k = 0; k < 8; k++) begin wait_pend(); send_rsp({32'($urandom), 32'(k)}); end end
      begin cyc(6); u_s_tready = 1'b0; cyc(5); u_s_tready = 1'b1; end
    join
    check("rr_all_granted", 64'(exp_grant_q.size()), 64'd0);

    // Full FIFO blocks arbitration until a response frees a slot
    send_req(0, 64'h0F00_0000_0000_0001);
    send_req(2, 64'h2F00_0000_0000_0002);
    send_req(3, 64'h3F00_0000_0000_0003);
    send_req(0, 64'h0F00_0000_0000_0004);
    fork send_req(1, 64'h1F00_0000_0000_0005); join_none
    repeat (20) begin
      @(negedge clk);
      check("full_req_tready", 64'(req_tready), 64'd0);
      check("full_u_s_tvalid", 64'(u_s_tvalid), 64'd0);
    end
    @(posedge clk);
    #1;
    fork send_rsp(64'h5555_0000_0000_0001); join_none
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      @(negedge clk);
      if (req_tready[1]) seen = 1'b1;
    end
    check("full_release_grant", 64'(seen), 64'd1);
    wait fork;
    for (int k = 0; k < 4; k++) begin wait_pend(); send_rsp({32'h6666_0000, 32'(k)}); end

    // In-order routing with a held-off head requester
    send_req(2, 64'h2A2A_0000_0000_0001);
    send_req(0, 64'h0B0B_0000_0000_0002);
    send_req(3, 64'h3C3C_0000_0000_0003);
    send_rsp(64'hAAAA_0000_0000_000A);
    rsp_tready = 4'b1110;
    fork send_rsp(64'hBBBB_0000_0000_000B); join_none
    repeat (3) begin
      @(negedge clk);
      check("hold_u_m_tready", 64'(u_m_tready), 64'd0);
      check("hold_rsp_tvalid", 64'(rsp_tvalid), 64'h1);
    end
    @(posedge clk);
    #1;
    rsp_tready = '1;
    wait fork;
    send_rsp(64'hCCCC_0000_0000_000C);

    // Orphan response, then reset while in FWD
    send_req(1, 64'h1D1D_0000_0000_0001);
    wait_pend();
    send_rsp(64'h1111_0000_0000_0001);
    send_rsp(64'h0999_0000_0000_0099);
    @(negedge clk);
    check("orphan_flag", 64'(err_orphan), 64'd1);
    @(posedge clk);
    #1;
    u_s_tready            = 1'b0;
    req_tdata[64*1 +: 64] = 64'h1E1E_0000_0000_0001;
    req_tvalid[1]         = 1'b1;
    cyc(3);
    do_reset();
    @(negedge clk);
    check("rst_mid_u_s_tvalid", 64'(u_s_tvalid), 64'd0);
    check("rst_mid_orphan", 64'(err_orphan), 64'd0);
    check("rst_mid_outstanding", 64'(outstanding), 64'd0);
    req_tvalid[1] = 1'b0;
    u_s_tready    = 1'b1;
    @(posedge clk);
    #1;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(2);
    fork
      send_req(0, 64'h0E0E_0000_0000_0001);
      send_req(2, 64'h2E2E_0000_0000_0002);
      begin for (int k = 0; k < 2; k++) begin wait_pend(); send_rsp({32'h7777_0000, 32'(k)}); end end
    join
    check("rst_ptr_order", 64'(exp_grant_q.size()), 64'd0);

    // Randomized traffic with random backpressure on both sides
    fork
      begin
        fork
          req_stream(0, 12);
          req_stream(1, 12);
          req_stream(2, 12);
          req_stream(3, 12);
          rsp_stream(48);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          cyc(1);
          u_s_tready = ($urandom_range(0, 3) != 0);
          rsp_tready = 4'($urandom_range(0, 15));
        end
      end
    join
    u_s_tready = 1'b1;
    rsp_tready = '1;
    n = 0;
    while (mdl_cnt != 0 && n < 50) begin cyc(1); n++; end
    cyc(4);
    check("final_outstanding", 64'(outstanding), 64'd0);
    check("final_exp_empty", 64'(exp_id_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/wide_uart_rr_sched.md
Name: wide_uart_rr_sched

Overview:
- Shares one wide_uart 64-bit request/response channel between N_REQ requesters.
- Forward path: round-robin arbitration, one 64-bit word per grant, into the UART's s_axis.
- Return path: each 64-bit response word from the UART's m_axis goes back to the requester that issued the oldest unanswered request.
- Per-transaction requester IDs are held in an in-order ID FIFO.
- Sits between the host-side requester ports and the wide_uart instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_OUT, 4, maximum outstanding (sent, unanswered) requests; ID FIFO depth, power of two.
- ID_W, $clog2(N_REQ), requester ID width (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  reset; rst is synchronous, active-high, on clk
- req_tdata  input  64*N_REQ  request word, requester i at bits [64*i +: 64]
- req_tvalid  input  N_REQ  per-requester valid
- req_tready  output  N_REQ  per-requester ready
- rsp_tdata  output  64  response word, shared by all requesters
- rsp_tvalid  output  N_REQ  per-requester response valid, at most one bit high
- rsp_tready  input  N_REQ  per-requester response ready
- u_s_tdata  output  64  to wide_uart s_axis_tdata
- u_s_tvalid  output  1  to wide_uart s_axis_tvalid
- u_s_tready  input  1  from wide_uart s_axis_tready
- u_m_tdata  input  64  from wide_uart m_axis_tdata
- u_m_tvalid  input  1  from wide_uart m_axis_tvalid
- u_m_tready  output  1  to wide_uart m_axis_tready
- outstanding  output  $clog2(MAX_OUT)+1  current ID FIFO occupancy
- err_orphan  output  1  sticky: a response arrived with no outstanding request

Behaviour:
- Reset state:
  - FSM in ARB; grant = 0; rr_ptr = 0; ID FIFO empty; outstanding = 0; err_orphan = 0.
  - All tready and tvalid outputs are 0.
  - rsp_tdata = 0 until the first response is routed.
- Forward FSM, states ARB and FWD:
  - ARB: if FIFO not full and any req_tvalid is set, choose the first set bit scanning from rr_ptr upward, with wrap at N_REQ. Register it as grant and go to FWD. If nothing is chosen, stay in ARB.
  - ARB fixes the grant-to-drive latency at 1 cycle. No req_tready is asserted in ARB.
  - FWD, outputs: u_s_tvalid = req_tvalid[grant]; u_s_tdata = req_tdata[grant]; req_tready[grant] = u_s_tready. All other req_tready bits are 0.
  - FWD, on handshake (req_tvalid[grant] && u_s_tready): push grant into the ID FIFO; rr_ptr <= (grant+1) mod N_REQ; go to ARB.
  - FWD with the granted requester's tvalid low: return to ARB. No push; rr_ptr unchanged. This covers a requester that withdraws, which is tolerated.
  - Fairness: with all requesters continuously valid, each is granted once per N_REQ grants.
- Return path (combinational from FIFO head and handshake signals):
  - FIFO non-empty, head = h: rsp_tvalid[h] = u_m_tvalid; rsp_tdata = u_m_tdata; u_m_tready = rsp_tready[h]. Pop on handshake.
  - FIFO empty: u_m_tready = 1 and all rsp_tvalid = 0. Any u_m_tvalid word is consumed and dropped, and err_orphan is set. err_orphan stays set until rst.
  - rsp_tready of non-head requesters is ignored.
- FIFO boundary rules:
  - Full (outstanding == MAX_OUT): ARB grants nothing. A grant already in FWD cannot overflow, because grants are only issued while not full.
  - Push and pop in the same cycle: occupancy unchanged, pointers both advance with wrap mod MAX_OUT. This case is legal even when full.
  - outstanding = push count − pop count, saturating by construction in 0..MAX_OUT.
- Reset mid-operation: all state returns to reset values within the cycle rst is sampled. Any in-flight UART byte traffic is the wide_uart's responsibility; late responses after reset are flagged as orphans.
- Ordering: the UART link is strictly in-order, so the responder returns exactly one response word per request word, in order.

Decomposition:
- Package wide_uart_pkg:
  - typedef enum {ARB, FWD} sched_state_t;
  - localparam UART_WORD_W = 64;
  - function rr_pick(valid, ptr) returning the next index.
- One sub-module: id_fifo.
  - Synchronous FIFO with parameters WIDTH = ID_W, DEPTH = MAX_OUT.
  - Ports: push, pop, din, dout, full, empty, count.
  - dout is the head; it is valid when not empty and shows the head combinationally.

Test Plan:
- Single request: req0 sends 0x1122334455667788, u_s_tready = 1. Expect u_s_tvalid one cycle after req_tvalid and outstanding = 1. Then u_m drives 0xAABB…; expect rsp_tvalid = 4'b0001 with that data, and outstanding = 0 after the handshake.
- Round-robin: all 4 requesters continuously valid, 8 grants. Grant order must be 0,1,2,3,0,1,2,3. Stall u_s_tready for 5 cycles mid-sequence; the order must be unchanged.
- Full stall (MAX_OUT = 4): 4 requests outstanding with no responses, req1 valid. Expect req_tready = 0 and u_s_tvalid = 0 for 20 cycles. Send one response; req1 is granted within 2 cycles.
- In-order routing: requests from 2, 0, 3, then responses R_a, R_b, R_c. Expect R_a on rsp_tvalid[2], R_b on [0], R_c on [3]. Hold rsp_tready[0] low 3 cycles; u_m_tready must stay low for those 3 cycles.
- Orphan and reset: with FIFO empty, send a u_m word. Expect u_m_tready = 1, no rsp_tvalid, err_orphan = 1. Then assert rst for 1 cycle mid-FWD; expect err_orphan = 0, outstanding = 0, FSM in ARB, rr_ptr = 0.
